// File: rtl/sample_iter_ctrl.sv
// Raster-order sample sequencer: latches one triangle and its bounding box, then walks
// the sample grid inside the box at one sample per cycle. Optional MSAA decode: SAMPLE_ITER_MSAA_EN.
module sample_iter_ctrl #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [SIGFIG*VERTS*AXIS-1:0]     tri_R13S,
  input  logic [SIGFIG*COLORS-1:0]         color_R13U,
  input  logic [SIGFIG*4-1:0]              box_R13S,
  input  logic                             validTri_R13H,
  input  logic [3:0]                       subSample_R13U,
  input  logic                             stall_R14H,
  output logic                             rdy_R13H,
  output logic [SIGFIG*VERTS*AXIS-1:0]     tri_R14S,
  output logic [SIGFIG*COLORS-1:0]         color_R14U,
  output logic [SIGFIG*2-1:0]              sample_R14S,
  output logic                             validSamp_R14H
);

  localparam int TRI_W = SIGFIG * VERTS * AXIS;
  localparam int COL_W = SIGFIG * COLORS;
  localparam logic [SIGFIG-1:0] ONE_PIX = {{(SIGFIG-1){1'b0}}, 1'b1} << RADIX;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [TRI_W-1:0]    tri_q, tri_d;
  logic [COL_W-1:0]    color_q, color_d;
  logic [SIGFIG-1:0]   samp_x_q, samp_x_d;
  logic [SIGFIG-1:0]   samp_y_q, samp_y_d;
  logic                valid_q, valid_d;
  logic [SIGFIG-1:0]   step_q, step_d;
  logic [SIGFIG-1:0]   llx_q, llx_d;
  logic [SIGFIG-1:0]   urx_q, urx_d;
  logic [SIGFIG-1:0]   ury_q, ury_d;

  // Incoming box fields: [0]=lower-left, [1]=upper-right, x in the low word of each corner
  logic [SIGFIG-1:0]   box_llx, box_lly, box_urx, box_ury;
  assign box_llx = box_R13S[0*SIGFIG +: SIGFIG];
  assign box_lly = box_R13S[1*SIGFIG +: SIGFIG];
  assign box_urx = box_R13S[2*SIGFIG +: SIGFIG];
  assign box_ury = box_R13S[3*SIGFIG +: SIGFIG];

  logic [SIGFIG-1:0]   step_new;
`ifdef SAMPLE_ITER_MSAA_EN
  always_comb begin
    case (subSample_R13U)
      4'b1000: step_new = ONE_PIX;
      4'b0100: step_new = ONE_PIX >> 1;
      4'b0010: step_new = ONE_PIX >> 2;
      4'b0001: step_new = ONE_PIX >> 3;
      default: step_new = ONE_PIX;
    endcase
  end
`else
  logic unused_subsample;
  assign unused_subsample = ^subSample_R13U;
  assign step_new = ONE_PIX;
`endif

  // Clearing the low bits of a two's-complement value floors it, so negative corners snap correctly
  logic [SIGFIG-1:0]   snap_mask;
  logic [SIGFIG-1:0]   llx_snap, lly_snap;
  logic                box_empty;
  assign snap_mask = ~(step_new - {{(SIGFIG-1){1'b0}}, 1'b1});
  assign llx_snap  = box_llx & snap_mask;
  assign lly_snap  = box_lly & snap_mask;
  assign box_empty = ($signed(box_urx) < $signed(llx_snap)) ||
                     ($signed(box_ury) < $signed(lly_snap));

  // One extra bit of headroom keeps the step-ahead compare from wrapping at the top of range
  logic signed [SIGFIG:0] x_next, y_next, urx_ext, ury_ext;
  assign x_next  = $signed({samp_x_q[SIGFIG-1], samp_x_q}) + $signed({1'b0, step_q});
  assign y_next  = $signed({samp_y_q[SIGFIG-1], samp_y_q}) + $signed({1'b0, step_q});
  assign urx_ext = $signed({urx_q[SIGFIG-1], urx_q});
  assign ury_ext = $signed({ury_q[SIGFIG-1], ury_q});

  always_comb begin
    state_d  = state_q;
    tri_d    = tri_q;
    color_d  = color_q;
    samp_x_d = samp_x_q;
    samp_y_d = samp_y_q;
    valid_d  = valid_q;
    step_d   = step_q;
    llx_d    = llx_q;
    urx_d    = urx_q;
    ury_d    = ury_q;
    case (state_q)
      IDLE: begin
        if (validTri_R13H) begin
          tri_d   = tri_R13S;
          color_d = color_R13U;
          step_d  = step_new;
          llx_d   = llx_snap;
          urx_d   = box_urx;
          ury_d   = box_ury;
          // An empty box is consumed without ever leaving IDLE
          if (!box_empty) begin
            state_d  = ITER;
            samp_x_d = llx_snap;
            samp_y_d = lly_snap;
            valid_d  = 1'b1;
          end
        end
      end
      ITER: begin
        if (!stall_R14H) begin
          if (x_next <= urx_ext) begin
            samp_x_d = x_next[SIGFIG-1:0];
          end else if (y_next <= ury_ext) begin
            samp_x_d = llx_q;
            samp_y_d = y_next[SIGFIG-1:0];
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      tri_q    <= '0;
      color_q  <= '0;
      samp_x_q <= '0;
      samp_y_q <= '0;
      valid_q  <= 1'b0;
      step_q   <= ONE_PIX;
      llx_q    <= '0;
      urx_q    <= '0;
      ury_q    <= '0;
    end else begin
      state_q  <= state_d;
      tri_q    <= tri_d;
      color_q  <= color_d;
      samp_x_q <= samp_x_d;
      samp_y_q <= samp_y_d;
      valid_q  <= valid_d;
      step_q   <= step_d;
      llx_q    <= llx_d;
      urx_q    <= urx_d;
      ury_q    <= ury_d;
    end
  end

  assign rdy_R13H       = (state_q == IDLE);
  assign tri_R14S       = tri_q;
  assign color_R14U     = color_q;
  assign sample_R14S    = {samp_y_q, samp_x_q};
  assign validSamp_R14H = valid_q;

endmodule
